// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl
// Brief    : Credit-based issue/collect controller for the 4-stage 64-bit
//            multiplier chain; optional perf counters via MULT_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_mplier,
  input  logic [63:0]      req_mcand,
  input  logic [TAG_W-1:0] req_tag,
  output logic             pipe_start,
  output logic [63:0]      pipe_mplier,
  output logic [63:0]      pipe_mcand,
  output logic [63:0]      pipe_product,
  input  logic             pipe_done,
  input  logic [63:0]      pipe_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_product,
  output logic [TAG_W-1:0] resp_tag
`ifdef MULT_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);

  logic [c_CNT_W-1:0] r_in_flight;
  logic [c_CNT_W-1:0] r_fifo_count;
  logic [c_CNT_W:0]   w_credits_used;
  logic               w_issue;
  logic               w_dec;
  logic               w_push;
  logic               w_pop;

  logic [LATENCY-1:0] r_tp_valid;
  logic [TAG_W-1:0]   r_tp_tag [LATENCY];

  logic [63+TAG_W:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;

  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both results still in the chain and results parked in the FIFO.
  assign w_credits_used = {1'b0, r_in_flight} + {1'b0, r_fifo_count};
  assign req_ready      = reset | (w_credits_used < c_DEPTH_EXT);
  assign w_issue        = req_valid & req_ready & ~reset;

  assign pipe_start   = w_issue;
  assign pipe_mplier  = req_mplier;
  assign pipe_mcand   = req_mcand;
  assign pipe_product = 64'd0;

  assign resp_valid   = ~reset & (r_fifo_count != '0);
  assign resp_product = r_mem[r_rd_ptr][63+TAG_W:TAG_W];
  assign resp_tag     = r_mem[r_rd_ptr][TAG_W-1:0];

  assign w_pop  = resp_valid & resp_ready;
  assign w_push = pipe_done & ~reset & ((r_fifo_count != c_DEPTH_CNT) | w_pop);
  // A stray done at zero in-flight must not underflow the credit counter.
  assign w_dec  = pipe_done & ((r_in_flight != '0) | w_issue);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tp_valid <= '0;
    end else begin
      r_tp_valid[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) begin
        r_tp_valid[i] <= r_tp_valid[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    r_tp_tag[0] <= req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      r_tp_tag[i] <= r_tp_tag[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_flight <= '0;
    end else begin
      case ({w_issue, w_dec})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {pipe_result, r_tp_tag[LATENCY-1]};
  end

  a_done_has_tag : assert property (@(posedge clock) disable iff (reset)
    pipe_done |-> r_tp_valid[LATENCY-1])
    else $error("pipe_done without a matching issued tag");

`ifdef MULT_CTRL_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_issue)                r_perf_issued <= r_perf_issued + 1'b1;
      if (req_valid & ~req_ready) r_perf_stall  <= r_perf_stall + 1'b1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_ctrl
// Brief    : Self-checking bench for mult_ctrl with a behavioural chain model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_ctrl;
  localparam int DEPTH = 8;

  logic        clock = 0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [63:0] req_mplier, req_mcand;
  logic [4:0]  req_tag;
  logic        pipe_start;
  logic [63:0] pipe_mplier, pipe_mcand, pipe_product;
  logic        pipe_done;
  logic [63:0] pipe_result;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_product;
  logic [4:0]  resp_tag;
`ifdef MULT_CTRL_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  mult_ctrl #(.LATENCY(4), .FIFO_DEPTH(DEPTH), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mplier(req_mplier), .req_mcand(req_mcand), .req_tag(req_tag),
    .pipe_start(pipe_start), .pipe_mplier(pipe_mplier), .pipe_mcand(pipe_mcand),
    .pipe_product(pipe_product), .pipe_done(pipe_done), .pipe_result(pipe_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_tag(resp_tag)
`ifdef MULT_CTRL_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Four-stage multiplier chain: start -> done four cycles later, cleared by reset.
  logic        st_v [4];
  logic [63:0] st_p [4];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) st_v[i] <= 1'b0;
    end else begin
      st_v[0] <= pipe_start;
      st_p[0] <= pipe_product + pipe_mplier * pipe_mcand;
      for (int i = 1; i < 4; i++) begin
        st_v[i] <= st_v[i-1];
        st_p[i] <= st_p[i-1];
      end
    end
  end
  assign pipe_done   = st_v[3];
  assign pipe_result = st_p[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: each accepted request becomes visible five cycles later, in order.
  typedef struct { logic [63:0] p; logic [4:0] t; int rdy; } exp_t;
  typedef struct { int c; logic [63:0] p; logic [4:0] t; } rec_t;
  exp_t q[$];
  rec_t log_q[$];
  int   outstanding = 0;
  int   stall_cnt   = 0;

  always @(negedge clock) begin
    logic exp_ready, exp_rv;
    if (reset) begin
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_pipe_start", {63'd0, pipe_start}, 64'd0);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      q.delete();
      outstanding = 0;
      stall_cnt   = 0;
    end else begin
      exp_ready = (outstanding < DEPTH);
      exp_rv    = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
      chk("pipe_start", {63'd0, pipe_start}, {63'd0, req_valid & exp_ready});
      chk("pipe_product", pipe_product, 64'd0);
      if (req_valid) chk("pipe_mplier", pipe_mplier, req_mplier);
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_rv});
      if (exp_rv && resp_valid) begin
        chk("resp_product", resp_product, q[0].p);
        chk("resp_tag", {59'd0, resp_tag}, {59'd0, q[0].t});
      end
      if (resp_valid && resp_ready) log_q.push_back('{cyc, resp_product, resp_tag});
      if (req_valid && exp_ready) begin
        q.push_back('{req_mplier * req_mcand, req_tag, cyc + 5});
        outstanding++;
      end
      if (req_valid && !exp_ready) stall_cnt++;
      if (exp_rv && resp_ready) begin
        void'(q.pop_front());
        outstanding--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                      output int acc);
    bit ok = 0;
    int n = 0;
    acc = -1;
    req_valid = 1; req_mplier = a; req_mcand = b; req_tag = t;
    while (!ok && n < 50) begin
      @(negedge clock);
      ok = req_ready;
      if (ok) acc = cyc;
      n++;
      @(posedge clock); #1;
    end
    req_valid = 0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout tag=%0d got=stalled want=accept", t);
    end
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick(1);
    reset = 0;
  endtask

  initial begin
    int c0, base, acc, bp_tag, first;
    reset = 1; req_valid = 0; req_mplier = 0; req_mcand = 0; req_tag = 0; resp_ready = 1;
    tick(2);
    reset = 0;

    // Single op: 3*5 with tag 1, response five cycles after accept.
    base = log_q.size();
    send(64'd3, 64'd5, 5'd1, c0);
    tick(8);
    chk("single_count", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() > base) begin
      chk("single_cycle", 64'(log_q[base].c - c0), 64'd5);
      chk("single_product", log_q[base].p, 64'd15);
      chk("single_tag", {59'd0, log_q[base].t}, 64'd1);
    end

    // Low-64-bit wrap cases.
    base = log_q.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, acc);
    send(64'h1_0000_0000, 64'h1_0000_0000, 5'd3, acc);
    tick(8);
    chk("wrap_count", 64'(log_q.size() - base), 64'd2);
    if (log_q.size() >= base + 2) begin
      chk("wrap_prod0", log_q[base].p, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_prod1", log_q[base+1].p, 64'd0);
    end

    // Streaming: 20 back-to-back ops, one response per cycle in tag order.
    base = log_q.size();
    first = -1;
    for (int i = 0; i < 20; i++) begin
      send(64'(i), 64'(i + 1), 5'(i), acc);
      if (i == 0) first = acc;
      chk("stream_no_stall", 64'(acc - first), 64'(i));
    end
    tick(10);
    chk("stream_count", 64'(log_q.size() - base), 64'd20);
    for (int i = 0; i < 20 && base + i < log_q.size(); i++) begin
      chk("stream_tag", {59'd0, log_q[base+i].t}, 64'(i));
      chk("stream_cycle", 64'(log_q[base+i].c - first), 64'(5 + i));
      chk("stream_prod", log_q[base+i].p, 64'(i * (i + 1)));
    end

    // Reset with three ops in flight: nothing returns, next op returns normally.
    base = log_q.size();
    send(64'd7, 64'd7, 5'd4, acc);
    send(64'd8, 64'd8, 5'd5, acc);
    send(64'd9, 64'd9, 5'd6, acc);
    pulse_reset();
    tick(8);
    chk("rst_discard", 64'(log_q.size() - base), 64'd0);
    chk("rst_ready_after", {63'd0, req_ready}, 64'd1);
    send(64'd11, 64'd13, 5'd7, c0);
    tick(8);
    chk("rst_next_count", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() > base) begin
      chk("rst_next_cycle", 64'(log_q[base].c - c0), 64'd5);
      chk("rst_next_prod", log_q[base].p, 64'd143);
    end

    // Backpressure: consumer stalled, requests every cycle.
    pulse_reset();
    base = log_q.size();
    resp_ready = 0;
    bp_tag = 8;
    for (int k = 0; k < 17; k++) begin
      resp_ready = (k == 12);
      req_valid = 1; req_tag = 5'(bp_tag);
      req_mplier = 64'(bp_tag); req_mcand = 64'd100;
      @(negedge clock);
      if (req_ready) bp_tag++;
      @(posedge clock); #1;
      if (k == 11) chk("bp_accepts_8", 64'(bp_tag - 8), 64'd8);
    end
    req_valid = 0;
    resp_ready = 0;
    chk("bp_accepts_9", 64'(bp_tag - 8), 64'd9);
    chk("bp_stalls", 64'(stall_cnt), 64'd8);
`ifdef MULT_CTRL_PERF_EN
    chk("perf_issued", {32'd0, perf_issued}, 64'd9);
    chk("perf_stall", {32'd0, perf_stall}, 64'(stall_cnt));
`endif
    resp_ready = 1;
    tick(15);
    chk("bp_drained", 64'(log_q.size() - base), 64'd9);
    for (int i = 0; i < 9 && base + i < log_q.size(); i++) begin
      chk("bp_tag", {59'd0, log_q[base+i].t}, 64'(8 + i));
      chk("bp_prod", log_q[base+i].p, 64'((8 + i) * 100));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mult_ctrl.md
# mult_ctrl

Issue/collect controller wrapped around the 4-stage pipelined 64-bit multiplier chain. It accepts tagged multiply requests on a valid/ready port and drives the first multiplier stage with `start`, operands and a zero partial product. It captures the final stage's `done`/`product_out` into a result FIFO and returns low-64-bit products with their tags on a valid/ready response port. The stage chain cannot stall, so a credit counter admits a request only when the FIFO is guaranteed a free slot for its result.

## Interface
- `LATENCY`, 4: cycles from `pipe_start` to `pipe_done`; must equal the number of chained stages.
- `FIFO_DEPTH`, 8: result FIFO entries; legal range 2..64. Full throughput requires `FIFO_DEPTH >= LATENCY+2`.
- `TAG_W`, 5: request tag width.

- `clock`  in  1  clock; all state updates on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle if `req_valid` is also high.
- `req_mplier`  in  64  multiplier operand.
- `req_mcand`  in  64  multiplicand operand.
- `req_tag`  in  TAG_W  opaque tag returned with the result.
- `pipe_start`  out  1  to stage 1 `start`.
- `pipe_mplier`, `pipe_mcand`  out  64  to stage 1 operand inputs.
- `pipe_product`  out  64  to stage 1 `product_in`; constant 0.
- `pipe_done`  in  1  from last stage `done`.
- `pipe_result`  in  64  from last stage `product_out`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts.
- `resp_product`  out  64  low 64 bits of mplier*mcand.
- `resp_tag`  out  TAG_W  tag of this result.

## Operation
- Issue: `pipe_start = req_valid & req_ready`. `pipe_mplier`/`pipe_mcand` pass `req_*` through combinationally. `req_ready` depends only on registered state, never on `req_valid`.
- Tag pipe: `LATENCY`-deep shift register of {valid, tag}, loaded on issue and advanced every cycle. Its output tag is paired with `pipe_done`.
- Credits: `in_flight` increments on issue and decrements on `pipe_done`. `fifo_count` increments on FIFO write and decrements on pop. `req_ready = (in_flight + fifo_count) < FIFO_DEPTH`, computed from registered values. Both counters are `$clog2(FIFO_DEPTH+1)` bits wide.
- Simultaneous increment and decrement on the same counter leaves it unchanged.
- FIFO: on `pipe_done`, write {`pipe_result`, tag-pipe tag}.
  - Pop on `resp_valid & resp_ready`.
  - `resp_*` are driven from the registered head entry.
  - No bypass: an empty FIFO written this cycle shows `resp_valid` next cycle.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Read and write pointers wrap modulo `FIFO_DEPTH`; non-power-of-2 depth is supported.
- Ordering: responses return strictly in issue order.
- Arithmetic: result is the low 64 bits of the product. Signed and unsigned operands give identical low bits, so no sign handling is done.
- Error: `pipe_done` with tag-pipe valid = 0 is a protocol fault.
  - The write still occurs.
  - `in_flight` saturates at 0.
- Reset:
  - Clears `in_flight`, `fifo_count`, pointers and tag-pipe valids.
  - In-flight operations are discarded; the stages' `done` also clears on the same reset.
  - Output values during and after reset: `req_ready`=1 (reset is ignored for accept purposes while high: `pipe_start` forced 0), `pipe_start`=0, `resp_valid`=0, `pipe_product`=0.

## Timing
- Request accepted in cycle 0 → `pipe_start` high in cycle 0 → `pipe_done` in cycle `LATENCY` (4) → `resp_valid` in cycle 5. Accept-to-response latency is 5 cycles.
- Throughput is 1 request/cycle with `resp_ready` held high and `FIFO_DEPTH >= 6`.
- Backpressure: `req_ready` falls the cycle after `in_flight + fifo_count` reaches `FIFO_DEPTH`. It rises the cycle after a pop frees a credit.
- `resp_*` stay stable while `resp_valid & !resp_ready`.

## Configuration
- `MULT_CTRL_PERF_EN`
  - Defined: adds output ports `perf_issued` [31:0], counting accepted requests, and `perf_stall` [31:0], counting cycles with `req_valid & !req_ready`. Both clear on reset and wrap on overflow.
  - Undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single op: mplier=3, mcand=5, tag=1 accepted at cycle 0 → `pipe_start` cycle 0; `resp_valid` cycle 5 with product=15, tag=1.
- Wrap: mplier=64'hFFFF_FFFF_FFFF_FFFF, mcand=2 → product=64'hFFFF_FFFF_FFFF_FFFE. Also 64'h1_0000_0000 × 64'h1_0000_0000 → 0.
- Streaming: 20 back-to-back requests (tags 0..19, mplier=i, mcand=i+1), `resp_ready`=1 → `req_ready` never drops; responses in tag order, one per cycle starting cycle 5.
- Backpressure: `resp_ready`=0, requests every cycle → exactly 8 accepted, then `req_ready`=0. Raise `resp_ready` for one cycle → one pop, then one more accept; no result lost.
- Reset mid-operation: 3 requests in flight, assert `reset` 1 cycle → `resp_valid` stays 0 afterwards; counters zero; next request returns correctly at +5 cycles.
- `MULT_CTRL_PERF_EN` build, backpressure scenario → `perf_issued`=9, `perf_stall` equals the counted stall cycles.
